chunk_serial_adder: RTL and testbench
=====================================

CHUNK_SERIAL_ADDER -- requirements
Module: chunk_serial_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand/result width; SHALL be a multiple of CHUNK and >= CHUNK.
REQ-002 Parameter CHUNK, default 4: bits added per cycle; N = WIDTH/CHUNK chunk cycles per operation.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand request valid.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in (add mode only).
REQ-010 sub  input  1  0 = A+B+cin, 1 = A-B (A + ~B + 1; cin ignored).
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 sum  output  WIDTH  result, bits WIDTH-1:0.
REQ-014 cout  output  1  carry out of bit WIDTH-1 (in sub mode, 1 = no borrow).
REQ-015 ovf  output  1  signed overflow = carry into MSB XOR cout.

Function
REQ-016 FSM states IDLE, RUN, DONE; in_ready SHALL be 1 exactly in IDLE, out_valid SHALL be 1 exactly in DONE.
REQ-017 IDLE: on in_valid & in_ready, latch a, b (inverted when sub=1), and carry register (cin, or 1 when sub=1), clear chunk index to 0, go to RUN.
REQ-018 RUN: each cycle add chunk k of A, chunk k of effective B, carry register; write the CHUNK-bit result into sum bits [k*CHUNK +: CHUNK]; update carry register with chunk carry-out; k increments.
REQ-019 On chunk k = N-1: capture cout and ovf, go to DONE; chunk index SHALL NOT wrap past N-1.
REQ-020 Latency: request accepted at edge t -> out_valid high after edge t+N; sum/cout/ovf stable while out_valid=1.
REQ-021 DONE: hold all outputs until out_valid & out_ready; on that edge go to IDLE; next request is accepted no earlier than the following edge (one op per N+2 cycles max).
REQ-022 in_valid during RUN/DONE SHALL be ignored (not latched); a, b, cin, sub changes after acceptance SHALL NOT affect the result.
REQ-023 Partially computed sum bits MAY be visible during RUN; consumers sample only when out_valid=1.
REQ-024 N = 1 (CHUNK = WIDTH) SHALL work: one RUN cycle, then DONE.

Reset
REQ-025 rst_n low SHALL asynchronously force state IDLE, chunk index 0, carry 0, sum 0, cout 0, ovf 0, out_valid 0; in_ready therefore 1 after reset.
REQ-026 Reset asserted mid-RUN or in DONE SHALL abandon the operation; no out_valid SHALL follow for it.
REQ-027 Operand registers need no reset value.

Structure
REQ-028 Shared package chunk_serial_adder_pkg SHALL hold the state enum (IDLE, RUN, DONE) and a function computing N and the chunk-index width clog2(N), minimum 1.
REQ-029 One combinational sub-module chunk_adder (parameter CHUNK; inputs a, b, cin; outputs s, cout, c_msb = carry into MSB) SHALL implement the per-chunk ripple add; chunk_serial_adder instantiates it once.
REQ-030 Parameter check SHALL fail elaboration when WIDTH % CHUNK != 0.

Verification (WIDTH=16, CHUNK=4 unless stated)
REQ-031 a=0x1234, b=0x4321, cin=1, sub=0, out_ready=1 -> out_valid 4 cycles after accept, sum=0x5556, cout=0, ovf=0, in_ready back to 1 one cycle later.
REQ-032 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; carry ripples across all 4 chunks.
REQ-033 a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, ovf=1; a=0x0003, b=0x0005, sub=1 -> sum=0xFFFE, cout=0, ovf=0.
REQ-034 Result ready, out_ready held 0 for 5 cycles, in_valid pulsed with new operands -> outputs unchanged, in_ready=0, new request not latched; out_ready=1 -> IDLE.
REQ-035 rst_n pulsed low in 2nd RUN cycle -> all outputs reset immediately, out_valid never asserts for that op; next op 0x0001+0x0001 -> 0x0002.
REQ-036 WIDTH=8, CHUNK=8 and WIDTH=32, CHUNK=1 random add/sub, 1000 ops each against a reference model, random out_ready stalls -> zero mismatches, latency exactly N.

Source files
------------

// File: rtl/chunk_serial_adder_pkg.sv
// chunk_serial_adder_pkg
// Shared definitions for the chunk-serial adder:
//   state_e     - controller states (IDLE, RUN, DONE)
//   num_chunks  - number of chunk cycles per operation (WIDTH / CHUNK)
//   idx_width   - width of the chunk index register, clog2(N) but at least 1
package chunk_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int num_chunks(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A single-chunk configuration still needs a 1-bit index register.
  function automatic int idx_width(input int width, input int chunk);
    int n;
    n = width / chunk;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// chunk_adder
// Combinational ripple adder for one CHUNK-bit slice.
// Ports:
//   a, b   - CHUNK-bit addends
//   cin    - carry into bit 0
//   s      - CHUNK-bit sum
//   cout   - carry out of bit CHUNK-1
//   c_msb  - carry into bit CHUNK-1 (used for signed overflow)
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/chunk_serial_adder.sv
// chunk_serial_adder
// Multi-cycle adder/subtractor that processes CHUNK bits per clock, taking
// N = WIDTH/CHUNK cycles per operation.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid, in_ready  - request handshake (in_ready high only when idle)
//   a, b, cin, sub      - operands; sub=1 computes a - b and ignores cin
//   out_valid, out_ready- result handshake (out_valid high only when done)
//   sum, cout, ovf      - result, carry out of MSB, signed overflow
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high; the producer holds its data stable while valid is high and not yet
// accepted. sum/cout/ovf hold while out_valid is high.
module chunk_serial_adder
  import chunk_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N    = num_chunks(WIDTH, CHUNK);
  localparam int IDXW = idx_width(WIDTH, CHUNK);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  if ((CHUNK < 1) || (WIDTH < CHUNK) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
    $error("chunk_serial_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_e            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;

  logic [CHUNK-1:0]  a_chunk, b_chunk, s_chunk;
  logic              chunk_cout, chunk_cmsb;

  // Chunk select as a constant-indexed mux so every slice bound is static.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int k = 0; k < N; k++) begin
      if (idx_q == IDXW'(k)) begin
        a_chunk = a_q[k*CHUNK +: CHUNK];
        b_chunk = b_q[k*CHUNK +: CHUNK];
      end
    end
  end

  chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
    .a     (a_chunk),
    .b     (b_chunk),
    .cin   (carry_q),
    .s     (s_chunk),
    .cout  (chunk_cout),
    .c_msb (chunk_cmsb)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtraction is A + ~B + 1: invert B here and seed carry with 1.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int k = 0; k < N; k++) begin
          if (idx_q == IDXW'(k)) begin
            sum_d[k*CHUNK +: CHUNK] = s_chunk;
          end
        end
        carry_d = chunk_cout;
        if (idx_q == LAST_IDX) begin
          cout_d  = chunk_cout;
          ovf_d   = chunk_cmsb ^ chunk_cout;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Operands are only read in RUN, which is always entered via a load.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_chunk_serial_adder.sv
// tb_chunk_serial_adder
// Directed vector table and corner sequences on the 16/4 configuration, plus
// randomized add/sub runs on the 8/8 (N=1) and 32/1 (N=32) configurations.
module tb_chunk_serial_adder;

  localparam int N16 = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 16/4 instance
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum;

  // 8/8 instance
  logic        v8_in_valid, v8_in_ready, v8_cin, v8_sub, v8_out_valid, v8_out_ready, v8_cout, v8_ovf;
  logic [7:0]  v8_a, v8_b, v8_sum;

  // 32/1 instance
  logic        v32_in_valid, v32_in_ready, v32_cin, v32_sub, v32_out_valid, v32_out_ready, v32_cout, v32_ovf;
  logic [31:0] v32_a, v32_b, v32_sum;

  chunk_serial_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  chunk_serial_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8_in_valid), .in_ready(v8_in_ready),
    .a(v8_a), .b(v8_b), .cin(v8_cin), .sub(v8_sub), .out_valid(v8_out_valid),
    .out_ready(v8_out_ready), .sum(v8_sum), .cout(v8_cout), .ovf(v8_ovf)
  );

  chunk_serial_adder #(.WIDTH(32), .CHUNK(1)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32_in_valid), .in_ready(v32_in_ready),
    .a(v32_a), .b(v32_b), .cin(v32_cin), .sub(v32_sub), .out_valid(v32_out_valid),
    .out_ready(v32_out_ready), .sum(v32_sum), .cout(v32_cout), .ovf(v32_ovf)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vecs[9];

  typedef struct packed {
    logic [31:0] s;
    logic        co;
    logic        ov;
  } res_t;

  // Reference: full-width arithmetic; overflow from operand/result signs.
  function automatic res_t ref_model(input int w, input logic [31:0] x, input logic [31:0] y,
                                     input logic ci, input logic sb);
    logic [32:0] t;
    logic [31:0] mask, xe, ye;
    res_t        r;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    xe   = x & mask;
    ye   = sb ? (~y & mask) : (y & mask);
    t    = {1'b0, xe} + {1'b0, ye} + {32'd0, (sb ? 1'b1 : ci)};
    r.s  = t[31:0] & mask;
    r.co = t[w];
    r.ov = (xe[w-1] == ye[w-1]) && (r.s[w-1] != xe[w-1]);
    return r;
  endfunction

  // One operation on the 16/4 instance with out_ready held high.
  task automatic do_op(input logic [15:0] va, input logic [15:0] vb, input logic vcin,
                       input logic vsub, input logic [15:0] es, input logic eco,
                       input logic eov, input string tag);
    int guard;
    int lat;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check({tag, " in_ready"}, in_ready, 1'b1);
    in_valid = 1'b1; a = va; b = vb; cin = vcin; sub = vsub; out_ready = 1'b1;
    @(posedge clk); #1;
    // Scramble inputs after acceptance; result must not change.
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
    cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < N16 + 4);
    check({tag, " latency"}, lat, N16);
    check({tag, " sum"}, sum, es);
    check({tag, " cout"}, cout, eco);
    check({tag, " ovf"}, ovf, eov);
    @(posedge clk); #1;
    check({tag, " back_idle"}, {out_valid, in_ready}, 2'b01);
  endtask

  task automatic rand8(input int nops);
    int lat;
    int stall;
    res_t e;
    logic [7:0] va, vb;
    logic vc, vs;
    for (int i = 0; i < nops; i++) begin
      va = 8'($urandom); vb = 8'($urandom);
      vc = 1'($urandom_range(0, 1)); vs = 1'($urandom_range(0, 1));
      e = ref_model(8, {24'd0, va}, {24'd0, vb}, vc, vs);
      check("w8 in_ready", v8_in_ready, 1'b1);
      v8_in_valid = 1'b1; v8_a = va; v8_b = vb; v8_cin = vc; v8_sub = vs; v8_out_ready = 1'b0;
      @(posedge clk); #1;
      v8_in_valid = 1'b0; v8_a = 8'($urandom); v8_b = 8'($urandom);
      lat = 0;
      do begin
        @(posedge clk); #1;
        lat++;
      end while (!v8_out_valid && lat < 5);
      check("w8 latency", lat, 1);
      check("w8 result", {v8_sum, v8_cout, v8_ovf}, {e.s[7:0], e.co, e.ov});
      stall = $urandom_range(0, 3);
      repeat (stall) begin
        @(posedge clk); #1;
      end
      check("w8 held", {v8_out_valid, v8_sum, v8_cout, v8_ovf}, {1'b1, e.s[7:0], e.co, e.ov});
      v8_out_ready = 1'b1;
      @(posedge clk); #1;
      v8_out_ready = 1'b0;
      check("w8 released", v8_out_valid, 1'b0);
    end
  endtask

  task automatic rand32(input int nops);
    int lat;
    int stall;
    res_t e;
    logic [31:0] va, vb;
    logic vc, vs;
    for (int i = 0; i < nops; i++) begin
      va = $urandom; vb = $urandom;
      vc = 1'($urandom_range(0, 1)); vs = 1'($urandom_range(0, 1));
      e = ref_model(32, va, vb, vc, vs);
      check("w32 in_ready", v32_in_ready, 1'b1);
      v32_in_valid = 1'b1; v32_a = va; v32_b = vb; v32_cin = vc; v32_sub = vs; v32_out_ready = 1'b0;
      @(posedge clk); #1;
      v32_in_valid = 1'b0; v32_a = $urandom; v32_b = $urandom;
      lat = 0;
      do begin
        @(posedge clk); #1;
        lat++;
      end while (!v32_out_valid && lat < 36);
      check("w32 latency", lat, 32);
      check("w32 result", {v32_sum, v32_cout, v32_ovf}, {e.s, e.co, e.ov});
      stall = $urandom_range(0, 3);
      repeat (stall) begin
        @(posedge clk); #1;
      end
      check("w32 held", {v32_out_valid, v32_sum, v32_cout, v32_ovf}, {1'b1, e.s, e.co, e.ov});
      v32_out_ready = 1'b1;
      @(posedge clk); #1;
      v32_out_ready = 1'b0;
      check("w32 released", v32_out_valid, 1'b0);
    end
  endtask

  initial begin : main
    int lat;
    logic seen;

    vecs[0] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{16'h0010, 16'h0001, 1'b0, 1'b1, 16'h000F, 1'b1, 1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[8] = '{16'h00FF, 16'h0F01, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0};

    // Clock/reset
    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    v8_in_valid = 1'b0; v8_a = '0; v8_b = '0; v8_cin = 1'b0; v8_sub = 1'b0; v8_out_ready = 1'b0;
    v32_in_valid = 1'b0; v32_a = '0; v32_b = '0; v32_cin = 1'b0; v32_sub = 1'b0; v32_out_ready = 1'b0;
    #12;
    check("reset outputs", {in_ready, out_valid, sum, cout, ovf}, {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Vector table
    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
            vecs[i].s, vecs[i].co, vecs[i].ov, $sformatf("vec%0d", i));
    end

    // Result stalled by out_ready=0; a request pulse in DONE is ignored.
    out_ready = 1'b0;
    in_valid = 1'b1; a = 16'h1234; b = 16'h4321; cin = 1'b1; sub = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < N16 + 4);
    check("stall latency", lat, N16);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      check("stall hold", {out_valid, in_ready, sum, cout, ovf}, {1'b1, 1'b0, 16'h5556, 1'b0, 1'b0});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("stall release", {out_valid, in_ready}, 2'b01);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("stall no ghost op", {out_valid, in_ready}, 2'b01);

    // Reset during the second RUN cycle abandons the operation.
    in_valid = 1'b1; a = 16'hAAAA; b = 16'h1111; cin = 1'b0; sub = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrun reset", {in_ready, out_valid, sum, cout, ovf}, {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (N16 + 3) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("abandoned op silent", seen, 1'b0);
    do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, "post_reset");

    // Other configurations: N=1 and N=32.
    rand8(1000);
    rand32(1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
